iter_div_rem: RTL and testbench

- Multi-cycle restoring divider for the RV32M DIV/DIVU/REM/REMU group.
- Sits in the execute stage beside the combinational add/sub unit.
- The add/sub unit computes in one combinational pass; this block instead iterates one shift-subtract step per cycle and signals completion with a done pulse.
- The core stalls on busy and captures result on done.

---
 rtl/iter_div_rem_if.sv | 30 +++
 rtl/iter_div_rem.sv | 143 ++++++++++++++
 tb/tb_iter_div_rem.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/iter_div_rem_if.sv
// iter_div_rem_if: start/operand/result bundle between the execute stage and
// the iterative divider.
//   En          start request, sampled by the divider only while idle
//   Rs1, Rs2    dividend, divisor
//   funct3_1_0  op select: 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   result      quotient or remainder, held until the next accepted start
//   busy        divider is iterating; the core stalls while high
//   done        one-cycle completion pulse
// master = core side, slave = divider side.
interface iter_div_rem_if #(
  parameter int WIDTH = 32
);
  logic             En;
  logic [WIDTH-1:0] Rs1;
  logic [WIDTH-1:0] Rs2;
  logic [1:0]       funct3_1_0;
  logic [WIDTH-1:0] result;
  logic             busy;
  logic             done;

  modport master (
    output En, Rs1, Rs2, funct3_1_0,
    input  result, busy, done
  );

  modport slave (
    input  En, Rs1, Rs2, funct3_1_0,
    output result, busy, done
  );
endinterface

// File: rtl/iter_div_rem.sv
// iter_div_rem: multi-cycle restoring divider for DIV/DIVU/REM/REMU.
// One shift-subtract step per cycle on operand magnitudes, followed by a
// sign-fix cycle. Divide-by-zero and signed overflow finish immediately.
// Ports:
//   CLK    clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    iter_div_rem_if.slave (En, Rs1, Rs2, funct3_1_0 in;
//          result, busy, done out)
// Build option: define DIV_EARLY_EXIT_EN to finish immediately when the
// dividend magnitude is below the divisor magnitude (same values, shorter
// latency).
//
// state | meaning
// IDLE  | waiting for En; only state where a start is accepted
// CALC  | WIDTH shift-subtract iterations
// FIX   | sign correction and quotient/remainder select
// DONE  | result valid, done pulse, back to IDLE
module iter_div_rem #(
  parameter int WIDTH = 32
) (
  input  logic          CLK,
  input  logic          rst_n,
  iter_div_rem_if.slave bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] rem_q, quo_q, dvs_q, result_q;
  logic [CW-1:0]    cnt_q;
  logic             q_neg_q, r_neg_q, op_rem_q;

  // start-time decode
  logic             is_signed, is_rem, div_zero, sgn_ovf, early_exit, take_short, start;
  logic [WIDTH-1:0] a_mag, b_mag, short_res;

  assign is_signed = ~bus.funct3_1_0[0];
  assign is_rem    = bus.funct3_1_0[1];
  assign a_mag     = (is_signed && bus.Rs1[WIDTH-1]) ? -bus.Rs1 : bus.Rs1;
  assign b_mag     = (is_signed && bus.Rs2[WIDTH-1]) ? -bus.Rs2 : bus.Rs2;
  assign div_zero  = (bus.Rs2 == '0);
  assign sgn_ovf   = is_signed && (bus.Rs1 == MIN_NEG) && (bus.Rs2 == '1);

`ifdef DIV_EARLY_EXIT_EN
  assign early_exit = !div_zero && (a_mag < b_mag);
`else
  assign early_exit = 1'b0;
`endif

  assign take_short = div_zero | sgn_ovf | early_exit;
  assign start      = (state == IDLE) && bus.En;

  // Early exit returns the unmodified dividend as remainder, same as /0.
  always_comb begin
    short_res = '0;
    if (div_zero)     short_res = is_rem ? bus.Rs1 : '1;
    else if (sgn_ovf) short_res = is_rem ? '0 : bus.Rs1;
    else              short_res = is_rem ? bus.Rs1 : '0;
  end

  // one restoring step: {rem,quo} << 1, then trial subtract with an extra
  // bit so the borrow shows up as the sign
  logic [WIDTH:0]   rem_sh, trial;
  logic             trial_ok;
  logic [WIDTH-1:0] q_fix, r_fix, fix_res;

  assign rem_sh   = {rem_q, quo_q[WIDTH-1]};
  assign trial    = rem_sh - {1'b0, dvs_q};
  assign trial_ok = ~trial[WIDTH];

  assign q_fix   = q_neg_q ? -quo_q : quo_q;
  assign r_fix   = r_neg_q ? -rem_q : rem_q;
  assign fix_res = op_rem_q ? r_fix : q_fix;

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  logic busy_c, done_c;

  always_comb begin
    state_nxt = state;
    busy_c    = 1'b0;
    done_c    = 1'b0;
    case (state)
      IDLE: if (bus.En) state_nxt = take_short ? DONE : CALC;
      CALC: begin
        busy_c = 1'b1;
        if (cnt_q == '0) state_nxt = FIX;
      end
      FIX: begin
        busy_c    = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        done_c    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      op_rem_q <= 1'b0;
      result_q <= '0;
    end else begin
      if (start) begin
        op_rem_q <= is_rem;
        q_neg_q  <= is_signed & (bus.Rs1[WIDTH-1] ^ bus.Rs2[WIDTH-1]);
        r_neg_q  <= is_signed & bus.Rs1[WIDTH-1];
        rem_q    <= '0;
        quo_q    <= a_mag;
        dvs_q    <= b_mag;
        cnt_q    <= CW'(WIDTH - 1);
        if (take_short) result_q <= short_res;
      end
      if (state == CALC) begin
        cnt_q <= cnt_q - 1'b1;
        rem_q <= trial_ok ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        quo_q <= {quo_q[WIDTH-2:0], trial_ok};
      end
      // written on the FIX->DONE edge so result moves only in DONE
      if (state == FIX) result_q <= fix_res;
    end
  end

  assign bus.result = result_q;
  assign bus.busy   = busy_c;
  assign bus.done   = done_c;

endmodule

// File: tb/tb_iter_div_rem.sv
// Self-checking bench for iter_div_rem (WIDTH=32): directed cases followed by
// random operands, checked against an arithmetic reference model.
module tb_iter_div_rem;
  localparam int W = 32;
  localparam logic [W-1:0] MIN_NEG = 32'h8000_0000;

  logic CLK = 1'b0;
  logic rst_n;
  always #5 CLK = ~CLK;

  iter_div_rem_if #(.WIDTH(W)) bus ();

  iter_div_rem #(.WIDTH(W)) dut (
    .CLK   (CLK),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_pass = 0;
  int n_total = 0;
  logic [W-1:0] last_result = '0;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  function automatic longint magnitude(input logic [1:0] op, input logic [W-1:0] v);
    longint s;
    if (op[0]) return longint'({32'h0, v});
    s = longint'($signed(v));
    return (s < 0) ? -s : s;
  endfunction

  function automatic logic [W-1:0] ref_result(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb, q, r;
    if (b == '0) return op[1] ? a : '1;
    if (!op[0] && a == MIN_NEG && b == '1) return op[1] ? '0 : a;
    if (op[0]) return op[1] ? (a % b) : (a / b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    q = sa / sb;
    r = sa % sb;
    return op[1] ? r[W-1:0] : q[W-1:0];
  endfunction

  function automatic int ref_latency(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    if (b == '0) return 1;
    if (!op[0] && a == MIN_NEG && b == '1) return 1;
`ifdef DIV_EARLY_EXIT_EN
    if (magnitude(op, a) < magnitude(op, b)) return 1;
`endif
    return W + 2;
  endfunction

  // Called just after a negedge with the divider idle. Drives the start,
  // scrambles inputs afterwards, optionally pulses a stray 9/3 start at cycle
  // pulse_at, and also drives En in the done cycle (must be ignored).
  // Returns just after the negedge of the cycle following done.
  task automatic do_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input string tag, input int pulse_at);
    logic [W-1:0] exp;
    int lat, c;
    bit got_done, busy_ok, held_ok;
    exp = ref_result(op, a, b);
    lat = ref_latency(op, a, b);
    bus.En = 1'b1; bus.Rs1 = a; bus.Rs2 = b; bus.funct3_1_0 = op;
    c = 0; got_done = 0; busy_ok = 1; held_ok = 1;
    while (!got_done && c < 100) begin
      @(negedge CLK);
      c++;
      if (bus.done === 1'b1) got_done = 1;
      else begin
        if (bus.busy !== (lat > 1)) busy_ok = 0;
        if (bus.result !== last_result) held_ok = 0;
      end
      if (!got_done && c == pulse_at) begin
        bus.En = 1'b1; bus.Rs1 = 9; bus.Rs2 = 3; bus.funct3_1_0 = 2'b01;
      end else begin
        bus.En = got_done;
        bus.Rs1 = $urandom; bus.Rs2 = $urandom; bus.funct3_1_0 = 2'($urandom_range(0, 3));
      end
    end
    check($sformatf("%s result", tag), bus.result, exp);
    check($sformatf("%s latency", tag), W'(c), W'(lat));
    check($sformatf("%s busy/held", tag), {29'h0, busy_ok, held_ok, bus.busy}, 32'h6);
    @(negedge CLK);
    bus.En = 1'b0;
    check($sformatf("%s pulse/ignore", tag), {30'h0, bus.done, bus.busy}, 32'h0);
    last_result = exp;
  endtask

  initial begin
    bit seen;
    logic [1:0] op;
    logic [W-1:0] a, b;
    int kind;

    rst_n = 1'b0;
    bus.En = 1'b0; bus.Rs1 = '0; bus.Rs2 = '0; bus.funct3_1_0 = 2'b00;
    repeat (2) @(negedge CLK);
    check("reset result", bus.result, '0);
    check("reset busy/done", {30'h0, bus.busy, bus.done}, '0);
    rst_n = 1'b1;
    @(negedge CLK);

    do_op(2'b01, 32'd100, 32'd7, "divu 100/7", 0);
    do_op(2'b11, 32'd100, 32'd7, "remu 100/7", 0);
    do_op(2'b00, 32'hFFFF_FFF9, 32'd2, "div -7/2", 0);
    do_op(2'b10, 32'hFFFF_FFF9, 32'd2, "rem -7/2", 0);
    do_op(2'b00, 32'd7, 32'hFFFF_FFFE, "div 7/-2", 0);
    do_op(2'b01, 32'd5, 32'd0, "divu 5/0", 0);
    do_op(2'b10, 32'd5, 32'd0, "rem 5/0", 0);
    do_op(2'b00, MIN_NEG, 32'hFFFF_FFFF, "div ovf", 0);
    do_op(2'b10, MIN_NEG, 32'hFFFF_FFFF, "rem ovf", 0);
    do_op(2'b01, 32'd100, 32'd7, "divu stray en", 5);
    do_op(2'b01, 32'd9, 32'd3, "divu 9/3 b2b", 0);
    do_op(2'b01, 32'd3, 32'd10, "divu 3/10", 0);
    do_op(2'b11, 32'd3, 32'd10, "remu 3/10", 0);
    do_op(2'b01, 32'hFFFF_FFFF, 32'd1, "divu max/1", 0);

    // asynchronous reset in the middle of an operation
    bus.En = 1'b1; bus.Rs1 = 32'd1000; bus.Rs2 = 32'd3; bus.funct3_1_0 = 2'b01;
    @(negedge CLK);
    bus.En = 1'b0;
    repeat (9) @(negedge CLK);
    rst_n = 1'b0;
    #1;
    check("midop reset", {bus.result[29:0], bus.busy, bus.done}, '0);
    @(negedge CLK);
    rst_n = 1'b1;
    seen = 0;
    repeat (60) begin
      @(negedge CLK);
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) seen = 1;
    end
    check("no done after reset", {31'h0, seen}, '0);
    last_result = '0;

    for (int i = 0; i < 30; i++) begin
      op = 2'($urandom_range(0, 3));
      a = $urandom;
      kind = $urandom_range(0, 5);
      case (kind)
        0: b = '0;
        1: b = W'($urandom_range(1, 15));
        2: b = $urandom;
        3: b = -W'($urandom_range(1, 15));
        4: begin a = MIN_NEG; b = '1; end
        default: begin a = W'($urandom_range(0, 50)); b = $urandom; end
      endcase
      do_op(op, a, b, $sformatf("rand%0d op%0d", i, op), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
